puf_resp_ctrl: RTL

Sequencer for the ring-oscillator PUF bit cell. One start request makes the block walk a sequence of RO-pair challenges through the 16-RO `puf_bit` datapath. For each pair it resets the oscillators and counters, drives the two 4-bit selects, waits for the measurement-finished flag and captures the comparison bit. The captured bits form an NUM_BITS-wide response word handed to the host with a done pulse.

---
 rtl/puf_resp_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/puf_resp_ctrl.sv
// Challenge sequencer for the 16-RO PUF bit cell: walks NUM_BITS RO pairs and assembles the response word.
// Optional measurement watchdog is built when PUF_RESP_CTRL_TIMEOUT_EN is defined.
module puf_resp_ctrl #(
    parameter int NUM_BITS       = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [7:0]          challenge_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [NUM_BITS-1:0] response_o,
    output logic                puf_rst_o,
    output logic [3:0]          sel1_o,
    output logic [3:0]          sel2_o,
    input  logic                finish_i,
    input  logic                puf_bit_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_CAPTURE,
        ST_FINISH
    } state_t;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0] K_LAST = 4'(NUM_BITS - 1);

    state_t                state_q, state_d;
    logic [3:0]            k_q, k_d;
    logic [3:0]            base1_q, base1_d;
    logic [3:0]            base2_q, base2_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  blank_q, blank_d;
    logic                  rej_q, rej_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [NUM_BITS-1:0]   resp_q, resp_d;
    logic                  puf_rst_q, puf_rst_d;
    logic [3:0]            sel1_q, sel1_d;
    logic [3:0]            sel2_q, sel2_d;
    logic                  tmo_hit;

`ifdef PUF_RESP_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts every MEASURE cycle of the current bit, blanking included.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_ARM) begin
            tmo_d = '0;
        end else if (state_q == ST_MEASURE) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (state_q == ST_MEASURE) && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
        end
    endgenerate
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base1_d   = base1_q;
        base2_d   = base2_q;
        settle_d  = settle_q;
        blank_d   = blank_q;
        rej_d     = rej_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        resp_d    = resp_q;
        puf_rst_d = puf_rst_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;

        case (state_q)
            ST_IDLE: begin
                puf_rst_d = 1'b1;
                busy_d    = 1'b0;
                if (start_i) begin
                    base1_d = challenge_i[3:0];
                    base2_d = challenge_i[7:4];
                    resp_d  = '0;
                    k_d     = 4'd0;
                    busy_d  = 1'b1;
                    if (challenge_i[3:0] == challenge_i[7:4]) begin
                        // Same RO on both sides gives no entropy; reject without measuring.
                        err_d   = 1'b1;
                        rej_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        err_d    = 1'b0;
                        sel1_d   = challenge_i[3:0];
                        sel2_d   = challenge_i[7:4];
                        settle_d = '0;
                        state_d  = ST_ARM;
                    end
                end
            end

            ST_ARM: begin
                puf_rst_d = 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    puf_rst_d = 1'b0;
                    blank_d   = 1'b1;
                    state_d   = ST_MEASURE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_MEASURE: begin
                blank_d = 1'b0;
                if (!blank_q && finish_i) begin
                    puf_rst_d = 1'b1;
                    state_d   = ST_CAPTURE;
                end else if (tmo_hit) begin
                    puf_rst_d = 1'b1;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_FINISH;
                end
            end

            ST_CAPTURE: begin
                puf_rst_d = 1'b1;
                for (int i = 0; i < NUM_BITS; i++) begin
                    if (k_q == 4'(i)) begin
                        resp_d[i] = puf_bit_i;
                    end
                end
                if (k_q == K_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FINISH;
                end else begin
                    k_d      = k_q + 4'd1;
                    sel1_d   = base1_q + k_q + 4'd1;
                    sel2_d   = base2_q + k_q + 4'd1;
                    settle_d = '0;
                    state_d  = ST_ARM;
                end
            end

            ST_FINISH: begin
                puf_rst_d = 1'b1;
                if (rej_q) begin
                    // Rejected runs spend one extra cycle here so done lands at cycle 2.
                    rej_d  = 1'b0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            k_q       <= 4'd0;
            base1_q   <= 4'd0;
            base2_q   <= 4'd0;
            settle_q  <= '0;
            blank_q   <= 1'b0;
            rej_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            resp_q    <= '0;
            puf_rst_q <= 1'b1;
            sel1_q    <= 4'd0;
            sel2_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base1_q   <= base1_d;
            base2_q   <= base2_d;
            settle_q  <= settle_d;
            blank_q   <= blank_d;
            rej_q     <= rej_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            resp_q    <= resp_d;
            puf_rst_q <= puf_rst_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign response_o = resp_q;
    assign puf_rst_o  = puf_rst_q;
    assign sel1_o     = sel1_q;
    assign sel2_o     = sel2_q;

endmodule
